// File: rtl/run_det_pkg.sv
// Shared types and sizing helpers for the time-shared run-length detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ROTATE = 2'd2
    } state_t;

    localparam int HIT_CNT_W = 16;

    // Index width for a lane number; never narrower than one bit.
    function automatic int lane_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_det_arbiter_if.sv
// Lane-side request/data bundle plus detection-event outputs of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: ack tells each lane its presented bit was taken this cycle.
interface run_det_arbiter_if #(
    parameter int LANES = 4
);
    import run_det_pkg::*;

    localparam int LW = lane_w(LANES);

    logic [LANES-1:0]     req;
    logic [LANES-1:0]     bit_in;
    logic [LANES-1:0]     ack;
    logic [LANES-1:0]     grant;
    logic                 hit;
    logic [LW-1:0]        hit_lane;
    logic [HIT_CNT_W-1:0] hit_cnt;

    // Lane front-ends present bits and watch for acks and events.
    modport master (
        output req, bit_in,
        input  ack, grant, hit, hit_lane, hit_cnt
    );

    // The arbiter consumes bits and produces acks and events.
    modport slave (
        input  req, bit_in,
        output ack, grant, hit, hit_lane, hit_cnt
    );

endinterface

// File: rtl/run_det_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; any=0 when no lane requests.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] win,
    output logic [W-1:0] idx,
    output logic         any
);

    int         j;
    logic [W-1:0] jw;

    // Walk the lanes starting at ptr; the first one requesting wins.
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jw  = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jw = W'(j);
            if (!any && req[jw]) begin
                any     = 1'b1;
                win[jw] = 1'b1;
                idx     = jw;
            end
        end
    end

endmodule

// File: rtl/run_det_arbiter.sv
// Time-shares one RUN_LEN-ones detector across LANES serial lanes, round-robin.
// Latency: grant one falling edge after req; hit registered one cycle after the completing bit.
// Backpressure: one bit per cycle from the granted lane via ack; one bubble per rotation.
module run_det_arbiter
    import run_det_pkg::*;
#(
    parameter int                   LANES   = 4,
    parameter int                   RUN_LEN = 3,
    parameter int                   SLICE   = 8,
    parameter logic [HIT_CNT_W-1:0] HIT_SAT = '1
) (
    input logic              clk,
    input logic              rst_n,
    run_det_arbiter_if.slave bus
);

    localparam int LW = lane_w(LANES);
    localparam int RW = $clog2(RUN_LEN);
    localparam int SW = 8;

    // Scheduler state
    state_t           state_q, state_d;
    logic [LANES-1:0] grant_q, grant_d;
    logic [LW-1:0]    gidx_q, gidx_d;
    logic [LW-1:0]    rr_q, rr_d;
    logic [SW-1:0]    slice_q, slice_d;

    // Detector context and event outputs
    logic [RW-1:0]          run_q [LANES];
    logic [RW-1:0]          run_d [LANES];
    logic                   hit_q, hit_d;
    logic [LW-1:0]          hit_lane_q, hit_lane_d;
    logic [HIT_CNT_W-1:0]   cnt_q, cnt_d;

    // Picker results
    logic [LANES-1:0] pick_win;
    logic [LW-1:0]    pick_idx;
    logic             pick_any;

    // Per-cycle datapath terms for the granted lane
    logic             consume;
    logic             cur_bit;
    logic [RW-1:0]    run_cur;
    logic [RW:0]      run_inc;
    logic             completes;
    logic             last_slice;
    logic [LW-1:0]    next_ptr;

    rr_pick #(
        .N (LANES),
        .W (LW)
    ) u_pick (
        .req (bus.req),
        .ptr (rr_q),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign cur_bit    = bus.bit_in[gidx_q];
    assign run_cur    = run_q[gidx_q];
    assign run_inc    = {1'b0, run_cur} + (RW+1)'(1);
    assign completes  = (run_inc == (RW+1)'(RUN_LEN));
    assign last_slice = (slice_q == SW'(SLICE - 1));
    assign next_ptr   = (gidx_q == LW'(LANES - 1)) ? '0 : gidx_q + LW'(1);

    // FSM state register; everything moves on the falling edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            slice_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            slice_q <= slice_d;
        end
    end

    // FSM next state: load a winner, run the slice, rotate with one bubble.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        slice_d = slice_q;
        case (state_q)
            IDLE, ROTATE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_win;
                    gidx_d  = pick_idx;
                    slice_d = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            GRANT: begin
                // A dropped req or the final bit of the slice hands the pointer on.
                if (!consume || last_slice) begin
                    state_d = ROTATE;
                    grant_d = '0;
                    rr_d    = next_ptr;
                end else begin
                    slice_d = slice_q + SW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // FSM outputs: ack is live only while granted, so reset kills it at once.
    always_comb begin
        consume   = (state_q == GRANT) && bus.req[gidx_q];
        bus.ack   = grant_q & bus.req & {LANES{state_q == GRANT}};
        bus.grant = grant_q;
    end

    // Detector next values for the granted lane; other lanes keep their context.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            run_d[i] = run_q[i];
        end
        hit_d      = 1'b0;
        hit_lane_d = '0;
        cnt_d      = cnt_q;
        if (consume) begin
            if (!cur_bit) begin
                run_d[gidx_q] = '0;
            end else if (completes) begin
                // Non-overlapping: the completing one starts a fresh run.
                run_d[gidx_q] = '0;
                hit_d         = 1'b1;
                hit_lane_d    = gidx_q;
                if (cnt_q != HIT_SAT) begin
                    cnt_d = cnt_q + HIT_CNT_W'(1);
                end
            end else begin
                run_d[gidx_q] = run_cur + RW'(1);
            end
        end
    end

    // Detector registers: per-lane run context, event pulse and hit counter.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                run_q[i] <= '0;
            end
            hit_q      <= 1'b0;
            hit_lane_q <= '0;
            cnt_q      <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                run_q[i] <= run_d[i];
            end
            hit_q      <= hit_d;
            hit_lane_q <= hit_lane_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.hit      = hit_q;
    assign bus.hit_lane = hit_lane_q;
    assign bus.hit_cnt  = cnt_q;

endmodule

// File: tb/tb_run_det_arbiter.sv
// Directed bench for run_det_arbiter: per-lane bit patterns, hand-computed events.
// Latency: inputs driven just after rising edge, consumed at falling edge.
// Backpressure: a lane's next bit is presented only after its current bit is acked.
module tb_run_det_arbiter;
    import run_det_pkg::*;

    localparam int LANES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    run_det_arbiter_if #(.LANES(LANES)) bus1 ();
    run_det_arbiter_if #(.LANES(LANES)) bus2 ();

    run_det_arbiter #(
        .LANES   (LANES),
        .RUN_LEN (3),
        .SLICE   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Second copy with a tiny saturation ceiling so saturation is reachable quickly.
    run_det_arbiter #(
        .LANES   (LANES),
        .RUN_LEN (2),
        .SLICE   (8),
        .HIT_SAT (16'd5)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_err = 0;
    int n_chk = 0;

    logic [63:0] pat [LANES];
    int          len [LANES];
    int          pos [LANES];
    int          ack_cyc [LANES][64];
    int          hit_ln [$];
    int          hit_ps [$];
    int          ack_log [$];
    logic [3:0]  gnt_log [$];
    int          cyc = 0;
    logic [15:0] last_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -99;
    endfunction

    function automatic int ack_lane(input logic [3:0] a);
        for (int i = 0; i < LANES; i++) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    task automatic clear_logs();
        for (int i = 0; i < LANES; i++) begin
            pat[i] = '0;
            len[i] = 0;
            pos[i] = 0;
        end
        hit_ln.delete();
        hit_ps.delete();
        ack_log.delete();
        gnt_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst_n       = 1'b0;
        bus1.req    = '0;
        bus1.bit_in = '0;
        bus2.req    = '0;
        bus2.bit_in = '0;
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: present each lane's current bit, then log acks, grant and events.
    task automatic tick();
        logic [LANES-1:0] r;
        logic [LANES-1:0] b;
        @(posedge clk);
        for (int i = 0; i < LANES; i++) begin
            r[i] = (pos[i] < len[i]);
            b[i] = (pos[i] < 64) ? pat[i][pos[i][5:0]] : 1'b0;
        end
        bus1.req    = r;
        bus1.bit_in = b;
        #1;
        if (bus1.hit === 1'b1) begin
            hit_ln.push_back(int'(bus1.hit_lane));
            hit_ps.push_back(pos[bus1.hit_lane]);
        end
        ack_log.push_back(ack_lane(bus1.ack));
        gnt_log.push_back(bus1.grant);
        for (int i = 0; i < LANES; i++) begin
            if (bus1.ack[i] === 1'b1) begin
                if (pos[i] < 64) ack_cyc[i][pos[i][5:0]] = cyc;
                pos[i]++;
            end
        end
        last_cnt = bus1.hit_cnt;
        cyc++;
    endtask

    task automatic run_done(input string tag, input int budget);
        int n;
        bit busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            tick();
            n++;
            busy = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (pos[i] < len[i]) busy = 1'b1;
            end
        end
        check({tag, "_drain"}, 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int pulses;
        int n;

        bus1.req    = '0;
        bus1.bit_in = '0;
        bus2.req    = '0;
        bus2.bit_in = '0;

        // Reset values
        do_reset();
        #1;
        check("rst_grant", 32'(bus1.grant), 32'd0);
        check("rst_ack", 32'(bus1.ack), 32'd0);
        check("rst_hit", 32'(bus1.hit), 32'd0);
        check("rst_hit_lane", 32'(bus1.hit_lane), 32'd0);
        check("rst_hit_cnt", 32'(bus1.hit_cnt), 32'd0);

        // Lane 0 alone: 1,1,1,0,1,1,1 gives hits after bits 3 and 7
        clear_logs();
        pat[0] = 64'b1110111;
        len[0] = 7;
        run_done("t1", 40);
        check("t1_lat_ack0", 32'(ack_log[0]), 32'hFFFF_FFFF);
        check("t1_lat_ack1", 32'(ack_log[1]), 32'd0);
        check("t1_lat_gnt1", 32'(gnt_log[1]), 32'd1);
        check("t1_nhits", 32'(hit_ln.size()), 32'd2);
        check("t1_hit0_pos", 32'(qget(hit_ps, 0)), 32'd3);
        check("t1_hit1_pos", 32'(qget(hit_ps, 1)), 32'd7);
        check("t1_hit0_lane", 32'(qget(hit_ln, 0)), 32'd0);
        check("t1_hit1_lane", 32'(qget(hit_ln, 1)), 32'd0);
        check("t1_hit_cnt", 32'(last_cnt), 32'd2);

        // All four lanes held: 0,1,2,3,0 for eight acks each, one bubble between
        do_reset();
        clear_logs();
        for (int i = 0; i < LANES; i++) len[i] = 40;
        repeat (45) tick();
        for (int s = 0; s < 5; s++) begin
            int cnt;
            int ln;
            cnt = 0;
            ln  = s % LANES;
            for (int c = 1 + 9*s; c <= 8 + 9*s; c++) begin
                if (ack_log[c] == ln && gnt_log[c] == 4'(1 << ln)) cnt++;
            end
            check($sformatf("t2_seg%0d_acks", s), 32'(cnt), 32'd8);
        end
        for (int s = 0; s < 4; s++) begin
            check($sformatf("t2_bub%0d_gnt", s), 32'(gnt_log[9 + 9*s]), 32'd0);
            check($sformatf("t2_bub%0d_ack", s), 32'(ack_log[9 + 9*s]), 32'hFFFF_FFFF);
        end
        check("t2_hit_cnt", 32'(last_cnt), 32'd0);

        // Lane 2 ends its slice on 1,1, lane 3 takes a slice, lane 2 resumes with 1
        do_reset();
        clear_logs();
        pat[2] = 64'b111000000;
        len[2] = 9;
        len[3] = 8;
        run_done("t3", 60);
        check("t3_nhits", 32'(hit_ln.size()), 32'd1);
        check("t3_hit_lane", 32'(qget(hit_ln, 0)), 32'd2);
        check("t3_hit_pos", 32'(qget(hit_ps, 0)), 32'd9);
        check("t3_resume_gap", 32'(ack_cyc[2][8] - ack_cyc[2][7]), 32'd11);
        check("t3_lane3_start", 32'(ack_cyc[3][0] - ack_cyc[2][7]), 32'd2);
        check("t3_hit_cnt", 32'(last_cnt), 32'd1);

        // Lane 1: 1,1,1,1,1,1 then 1,1,0,1,1,1; slice boundary falls mid-pattern
        clear_logs();
        pat[1] = 64'b1110_1111_1111;
        len[1] = 12;
        run_done("t4", 60);
        check("t4_nhits", 32'(hit_ln.size()), 32'd3);
        check("t4_hit0_pos", 32'(qget(hit_ps, 0)), 32'd3);
        check("t4_hit1_pos", 32'(qget(hit_ps, 1)), 32'd6);
        check("t4_hit2_pos", 32'(qget(hit_ps, 2)), 32'd12);
        check("t4_hit2_lane", 32'(qget(hit_ln, 2)), 32'd1);
        check("t4_regrant_gap", 32'(ack_cyc[1][8] - ack_cyc[1][7]), 32'd2);
        check("t4_hit_cnt", 32'(last_cnt), 32'd4);

        // Reset mid-grant with run[0]=2, then two ones must not hit
        clear_logs();
        pat[0] = 64'b1111;
        len[0] = 4;
        n = 0;
        while (pos[0] < 2 && n < 20) begin
            tick();
            n++;
        end
        check("t5_two_acks", 32'(pos[0]), 32'd2);
        check("t5_mid_grant", 32'(gnt_log[gnt_log.size() - 1]), 32'd1);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ack", 32'(bus1.ack), 32'd0);
        check("t5_rst_grant", 32'(bus1.grant), 32'd0);
        check("t5_rst_hit_cnt", 32'(bus1.hit_cnt), 32'd0);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        clear_logs();
        pat[0] = 64'b11;
        len[0] = 2;
        run_done("t5", 20);
        check("t5_nhits", 32'(hit_ln.size()), 32'd0);
        check("t5_hit_cnt", 32'(last_cnt), 32'd0);

        // Saturation: 20 ones at RUN_LEN=2 give 10 pulses, counter pinned at 5
        acks   = 0;
        pulses = 0;
        n      = 0;
        while (acks < 20 && n < 100) begin
            @(posedge clk);
            bus2.req    = 4'b0001;
            bus2.bit_in = 4'b0001;
            #1;
            if (bus2.hit === 1'b1) pulses++;
            if (bus2.ack[0] === 1'b1) acks++;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            bus2.req = 4'b0000;
            #1;
            if (bus2.hit === 1'b1) pulses++;
        end
        check("t6_acks", 32'(acks), 32'd20);
        check("t6_pulses", 32'(pulses), 32'd10);
        check("t6_hit_cnt_sat", 32'(bus2.hit_cnt), 32'd5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
